ula_controle: RTL

ULA_CONTROLE -- requirements
Module: ula_controle

---
 rtl/ula_controle.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ula_controle.sv
// ---------------------------------------------------------------------------
// ula_controle
//
// Purpose:
//   Operator-entry sequencer in front of a 4-bit ULA. A single entry button
//   (strobeCtrl) is used to enter operand A, operand B and the operation
//   select in turn. The block then spends one cycle in EXEC while the
//   downstream ULA computes, captures the ULA result/status, and shows it
//   until the next entry press. No arithmetic is done here; all operands and
//   results are passed through at 4 bits.
//
// Optional feature:
//   ULA_CONTROLE_ACC_EN - accumulator mode. An entry press in SHOW loads the
//   shown result into operand A and jumps straight to WAIT_B.
//
// Ports:
//   clkCtrl      in   1  rising-edge clock
//   rstCtrl      in   1  asynchronous active-high reset
//   dataInCtrl   in   4  operand entry value
//   opInCtrl     in   3  operation select entry value (ULA encoding)
//   strobeCtrl   in   1  entry button level, already synchronized
//   clearCtrl    in   1  synchronous abort to WAIT_A
//   resultInCtrl in   4  ULA result
//   statusInCtrl in   1  ULA status
//   aOutCtrl     out  4  registered operand A to the ULA
//   bOutCtrl     out  4  registered operand B to the ULA
//   selOutCtrl   out  3  registered operation select to the ULA
//   resultCtrl   out  4  captured (normalized) result
//   statusCtrl   out  1  captured (normalized) status
//   doneCtrl     out  1  one-cycle pulse, result valid
//   stateCtrl    out  3  current FSM state encoding
//
// Handshake: doneCtrl is a one-cycle valid pulse with no ready/back-pressure;
// resultCtrl/statusCtrl become valid in that cycle and hold until the next
// capture, so a consumer may sample them at the pulse or any time after.
// ---------------------------------------------------------------------------
module ula_controle (
    input  logic       clkCtrl,
    input  logic       rstCtrl,
    input  logic [3:0] dataInCtrl,
    input  logic [2:0] opInCtrl,
    input  logic       strobeCtrl,
    input  logic       clearCtrl,
    input  logic [3:0] resultInCtrl,
    input  logic       statusInCtrl,
    output logic [3:0] aOutCtrl,
    output logic [3:0] bOutCtrl,
    output logic [2:0] selOutCtrl,
    output logic [3:0] resultCtrl,
    output logic       statusCtrl,
    output logic       doneCtrl,
    output logic [2:0] stateCtrl
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'b000,
        WAIT_B  = 3'b001,
        WAIT_OP = 3'b010,
        EXEC    = 3'b011,
        SHOW    = 3'b100
    } state_t;

    state_t state;
    logic   strobe_q;
    logic   entry_ev;

    // Rising edge of the button level. strobe_q resets to 1 so a button held
    // through reset release does not count as a press.
    assign entry_ev  = strobeCtrl & ~strobe_q;
    assign stateCtrl = state;

    always_ff @(posedge clkCtrl or posedge rstCtrl) begin
        if (rstCtrl) begin
            state      <= WAIT_A;
            strobe_q   <= 1'b1;
            aOutCtrl   <= 4'b0000;
            bOutCtrl   <= 4'b0000;
            selOutCtrl <= 3'b000;
            resultCtrl <= 4'b0000;
            statusCtrl <= 1'b0;
            doneCtrl   <= 1'b0;
        end else begin
            strobe_q <= strobeCtrl;
            doneCtrl <= 1'b0;
            if (clearCtrl) begin
                // Abort wins over a simultaneous press; registered data kept.
                state <= WAIT_A;
            end else begin
                case (state)
                    WAIT_A: begin
                        if (entry_ev) begin
                            aOutCtrl <= dataInCtrl;
                            state    <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (entry_ev) begin
                            bOutCtrl <= dataInCtrl;
                            state    <= WAIT_OP;
                        end
                    end
                    WAIT_OP: begin
                        if (entry_ev) begin
                            selOutCtrl <= opInCtrl;
                            state      <= EXEC;
                        end
                    end
                    EXEC: begin
                        // ULA inputs have been stable for this whole cycle;
                        // capture with per-operation normalization.
                        case (selOutCtrl)
                            3'b011: begin
                                // Compare-equal: only the flag is meaningful.
                                resultCtrl <= 4'b0000;
                                statusCtrl <= statusInCtrl;
                            end
                            3'b100, 3'b101: begin
                                resultCtrl <= resultInCtrl;
                                statusCtrl <= statusInCtrl;
                            end
                            default: begin
                                // Logic/arith ops: status is not exposed.
                                resultCtrl <= resultInCtrl;
                                statusCtrl <= 1'b0;
                            end
                        endcase
                        doneCtrl <= 1'b1;
                        state    <= SHOW;
                    end
                    SHOW: begin
                        if (entry_ev) begin
`ifdef ULA_CONTROLE_ACC_EN
                            aOutCtrl <= resultCtrl;
                            state    <= WAIT_B;
`else
                            state    <= WAIT_A;
`endif
                        end
                    end
                    default: begin
                        state <= WAIT_A;
                    end
                endcase
            end
        end
    end

endmodule
